// File: rtl/ecdsa_pkg.sv
// Shared ECDSA constants and the signature-finalize state encoding.
package ecdsa_pkg;

  localparam int unsigned W = 256;

  // secp256k1 group order n
  localparam logic [W-1:0] ECDSA_N =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

  localparam int unsigned ST_W = 3;

  typedef logic [ST_W-1:0] sig_state_t;

  localparam sig_state_t ST_IDLE = 3'd0;
  localparam sig_state_t ST_LOAD = 3'd1;
  localparam sig_state_t ST_MUL1 = 3'd2;
  localparam sig_state_t ST_ADD  = 3'd3;
  localparam sig_state_t ST_MUL2 = 3'd4;
  localparam sig_state_t ST_DONE = 3'd5;

endpackage

// File: rtl/mod_mul_serial.sv
// Bit-serial MSB-first interleaved modular multiplier: p = a*b mod N.
// The start cycle performs the first (MSB) iteration directly on the a/b
// inputs, so the product is in p and done pulses exactly 256 edges after start.
module mod_mul_serial #(
  parameter int unsigned W = 256,
  parameter logic [W-1:0] N = ecdsa_pkg::ECDSA_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] p
);

  localparam int unsigned CW = $clog2(W);

  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [W-1:0]  op_a;
  logic [W-1:0]  acc_in;
  logic          op_bit;
  logic [W:0]    dbl;
  logic [W-1:0]  dbl_red;
  logic [W:0]    sum;
  logic [W-1:0]  step;

  // One interleaved step: acc <- 2*acc mod N, then + a mod N if the b bit is set
  always_comb begin
    op_a    = start ? a : a_q;
    op_bit  = start ? b[W-1] : b_q[cnt_q];
    acc_in  = start ? '0 : acc_q;
    dbl     = {acc_in, 1'b0};
    dbl_red = (dbl >= {1'b0, N}) ? W'(dbl - {1'b0, N}) : W'(dbl);
    sum     = {1'b0, dbl_red} + {1'b0, (op_bit ? op_a : {W{1'b0}})};
    step    = (sum >= {1'b0, N}) ? W'(sum - {1'b0, N}) : W'(sum);
  end

  // Iteration sequencing: counter walks the remaining b bits from W-2 down to 0
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      a_d    = a;
      b_d    = b;
      acc_d  = step;
      cnt_d  = CW'(W - 2);
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d = step;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = acc_q;

endmodule

// File: rtl/ecdsa_sig_finalize.sv
// ECDSA signature finalize: r = Rx mod n, s = k_inv*(z + r*d) mod n,
// with a degenerate-signature flag so the controller can retry with a new nonce.
module ecdsa_sig_finalize
  import ecdsa_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] rx,
  input  logic [W-1:0] z,
  input  logic [W-1:0] d,
  input  logic [W-1:0] k_inv,
  output logic [W-1:0] r,
  output logic [W-1:0] s,
  output logic         err,
  output logic         out_valid,
  input  logic         out_ready
);

  // x mod n for x < 2n
  function automatic logic [W-1:0] reduce_once(input logic [W-1:0] x);
    return (x >= ECDSA_N) ? W'(x - ECDSA_N) : x;
  endfunction

  // (x + y) mod n for x, y < n
  function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] sum;
    sum = {1'b0, x} + {1'b0, y};
    return (sum >= {1'b0, ECDSA_N}) ? W'(sum - {1'b0, ECDSA_N}) : W'(sum);
  endfunction

  sig_state_t   state_q, state_d;
  logic [W-1:0] rx_q, rx_d;
  logic [W-1:0] z_q, z_d;
  logic [W-1:0] d_q, d_d;
  logic [W-1:0] kinv_q, kinv_d;
  logic [W-1:0] zr_q, zr_d;
  logic [W-1:0] r_q, r_d;
  logic [W-1:0] s_q, s_d;
  logic         err_q, err_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_q, in_ready_d;

  logic         mul_start;
  logic [W-1:0] mul_a;
  logic [W-1:0] mul_b;
  logic         mul_busy;
  logic         mul_done;
  logic [W-1:0] mul_p;

  logic [W-1:0] r_red;
  logic [W-1:0] z_red;
  logic [W-1:0] u_sum;

  // Single multiplier time-shared between r*d and k_inv*u
  mod_mul_serial #(
    .W (W),
    .N (ECDSA_N)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (mul_a),
    .b     (mul_b),
    .busy  (mul_busy),
    .done  (mul_done),
    .p     (mul_p)
  );

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    rx_d        = rx_q;
    z_d         = z_q;
    d_d         = d_q;
    kinv_d      = kinv_q;
    zr_d        = zr_q;
    r_d         = r_q;
    s_d         = s_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    mul_start   = 1'b0;
    mul_a       = kinv_q;
    mul_b       = d_q;
    r_red       = reduce_once(rx_q);
    z_red       = reduce_once(z_q);
    u_sum       = add_mod(zr_q, mul_p);

    case (state_q)
      ST_IDLE: begin
        if (in_valid && !mul_busy) begin
          rx_d    = rx;
          z_d     = z;
          d_d     = d;
          kinv_d  = k_inv;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        r_d  = r_red;
        zr_d = z_red;
        if (r_red == '0) begin
          s_d         = '0;
          err_d       = 1'b1;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          mul_start = 1'b1;
          mul_a     = r_red;
          mul_b     = d_q;
          state_d   = ST_MUL1;
        end
      end
      ST_MUL1: begin
        if (mul_done) begin
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        mul_start = 1'b1;
        mul_a     = kinv_q;
        mul_b     = u_sum;
        state_d   = ST_MUL2;
      end
      ST_MUL2: begin
        if (mul_done) begin
          s_d         = mul_p;
          err_d       = (mul_p == '0);
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rx_q        <= '0;
      z_q         <= '0;
      d_q         <= '0;
      kinv_q      <= '0;
      zr_q        <= '0;
      r_q         <= '0;
      s_q         <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      rx_q        <= rx_d;
      z_q         <= z_d;
      d_q         <= d_d;
      kinv_q      <= kinv_d;
      zr_q        <= zr_d;
      r_q         <= r_d;
      s_q         <= s_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign r         = r_q;
  assign s         = s_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ecdsa_sig_finalize.sv
// Directed testbench for ecdsa_sig_finalize with hand-computed expectations.
module tb_ecdsa_sig_finalize;

  localparam logic [255:0] NN = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
  localparam int LAT_NORMAL = 514;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] rx, z, d, k_inv;
  logic [255:0] r, s;
  logic         err;
  logic         out_valid;
  logic         out_ready;

  int nvec = 0;
  int nerr = 0;

  ecdsa_sig_finalize dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rx        (rx),
    .z         (z),
    .d         (d),
    .k_inv     (k_inv),
    .r         (r),
    .s         (s),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Present one operation from IDLE and wait (bounded) for out_valid.
  // With junk set, in_valid stays high with other operands while busy.
  task automatic run_op(input logic [255:0] rx_i, input logic [255:0] z_i,
                        input logic [255:0] d_i, input logic [255:0] k_i,
                        input bit junk, output int lat);
    rx = rx_i; z = z_i; d = d_i; k_inv = k_i;
    in_valid = 1'b1;
    @(posedge clk); #1;
    if (junk) begin
      rx = NN; z = 256'd99; d = 256'd3; k_inv = 256'd4;
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    while (!out_valid && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    rx = '0; z = '0; d = '0; k_inv = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    nvec++; if (in_ready !== 1'b1)  begin nerr++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    nvec++; if (err !== 1'b0)       begin nerr++; $display("FAIL reset_err: got %b want 0", err); end
    nvec++; if (r !== 256'd0)       begin nerr++; $display("FAIL reset_r: got %h want 0", r); end
    nvec++; if (s !== 256'd0)       begin nerr++; $display("FAIL reset_s: got %h want 0", s); end
  endtask

  task automatic test_trivial();
    int lat;
    run_op(256'd5, 256'd0, 256'd1, 256'd1, 1'b0, lat);
    nvec++; if (lat !== LAT_NORMAL) begin nerr++; $display("FAIL trivial_latency: got %0d want %0d", lat, LAT_NORMAL); end
    nvec++; if (r !== 256'd5)  begin nerr++; $display("FAIL trivial_r: got %h want 5", r); end
    nvec++; if (s !== 256'd5)  begin nerr++; $display("FAIL trivial_s: got %h want 5", s); end
    nvec++; if (err !== 1'b0)  begin nerr++; $display("FAIL trivial_err: got %b want 0", err); end
    @(posedge clk); #1;
    nvec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++; $display("FAIL trivial_handshake: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reduction();
    int lat;
    run_op(NN + 256'd3, NN + 256'd7, 256'd1, 256'd1, 1'b0, lat);
    nvec++; if (lat !== LAT_NORMAL) begin nerr++; $display("FAIL reduce_latency: got %0d want %0d", lat, LAT_NORMAL); end
    nvec++; if (r !== 256'd3)  begin nerr++; $display("FAIL reduce_r: got %h want 3", r); end
    nvec++; if (s !== 256'd10) begin nerr++; $display("FAIL reduce_s: got %h want a", s); end
    nvec++; if (err !== 1'b0)  begin nerr++; $display("FAIL reduce_err: got %b want 0", err); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    int lat;
    run_op(256'd2, 256'd0, NN - 256'd1, 256'd1, 1'b0, lat);
    nvec++; if (r !== 256'd2)        begin nerr++; $display("FAIL wrap_r: got %h want 2", r); end
    nvec++; if (s !== NN - 256'd2)   begin nerr++; $display("FAIL wrap_s: got %h want %h", s, NN - 256'd2); end
    nvec++; if (err !== 1'b0)        begin nerr++; $display("FAIL wrap_err: got %b want 0", err); end
    @(posedge clk); #1;
  endtask

  // 3*5 = 15, +4 = 19, *2 = 38; operands held on the inputs during the run must be ignored
  task automatic test_small_product();
    int lat;
    run_op(256'd3, 256'd4, 256'd5, 256'd2, 1'b1, lat);
    nvec++; if (lat !== LAT_NORMAL) begin nerr++; $display("FAIL small_latency: got %0d want %0d", lat, LAT_NORMAL); end
    nvec++; if (r !== 256'd3)  begin nerr++; $display("FAIL small_r: got %h want 3", r); end
    nvec++; if (s !== 256'd38) begin nerr++; $display("FAIL small_s: got %h want 26", s); end
    @(posedge clk); #1;
  endtask

  task automatic test_degenerate_r();
    int lat;
    run_op(NN, 256'd9, 256'd1, 256'd1, 1'b0, lat);
    nvec++; if (lat !== 1)     begin nerr++; $display("FAIL degen_r_latency: got %0d want 1", lat); end
    nvec++; if (r !== 256'd0)  begin nerr++; $display("FAIL degen_r_r: got %h want 0", r); end
    nvec++; if (s !== 256'd0)  begin nerr++; $display("FAIL degen_r_s: got %h want 0", s); end
    nvec++; if (err !== 1'b1)  begin nerr++; $display("FAIL degen_r_err: got %b want 1", err); end
    @(posedge clk); #1;
  endtask

  task automatic test_degenerate_s();
    int lat;
    run_op(256'd1, NN - 256'd1, 256'd1, 256'd7, 1'b0, lat);
    nvec++; if (lat !== LAT_NORMAL) begin nerr++; $display("FAIL degen_s_latency: got %0d want %0d", lat, LAT_NORMAL); end
    nvec++; if (r !== 256'd1)  begin nerr++; $display("FAIL degen_s_r: got %h want 1", r); end
    nvec++; if (s !== 256'd0)  begin nerr++; $display("FAIL degen_s_s: got %h want 0", s); end
    nvec++; if (err !== 1'b1)  begin nerr++; $display("FAIL degen_s_err: got %b want 1", err); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    run_op(256'd3, 256'd4, 256'd5, 256'd2, 1'b0, lat);
    nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL bp_valid: got %b want 1", out_valid); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      nvec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || r !== 256'd3 || s !== 256'd38 || err !== 1'b0) begin
        nerr++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b r=%h s=%h err=%b want 1/0/3/26/0",
                 i, out_valid, in_ready, r, s, err);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    nvec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    run_op(256'd2, 256'd0, NN - 256'd1, 256'd1, 1'b0, lat);
    nvec++; if (lat !== LAT_NORMAL || s !== NN - 256'd2) begin
      nerr++; $display("FAIL bp_second: lat=%0d s=%h want %0d / %h", lat, s, LAT_NORMAL, NN - 256'd2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    int lat;
    rx = 256'd3; z = 256'd4; d = 256'd5; k_inv = 256'd2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (101) begin @(posedge clk); #1; end
    nvec++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      nerr++; $display("FAIL mid_busy: out_valid=%b in_ready=%b want 0/0", out_valid, in_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    nvec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || r !== 256'd0 || s !== 256'd0 || err !== 1'b0) begin
      nerr++;
      $display("FAIL mid_reset: out_valid=%b in_ready=%b r=%h s=%h err=%b want 0/1/0/0/0",
               out_valid, in_ready, r, s, err);
    end
    run_op(256'd5, 256'd0, 256'd1, 256'd1, 1'b0, lat);
    nvec++; if (lat !== LAT_NORMAL || r !== 256'd5 || s !== 256'd5 || err !== 1'b0) begin
      nerr++; $display("FAIL mid_after: lat=%0d r=%h s=%h err=%b want %0d/5/5/0", lat, r, s, err, LAT_NORMAL);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    run_op(256'd3, 256'd4, 256'd5, 256'd2, 1'b0, lat);
    nvec++; if (s !== 256'd38) begin nerr++; $display("FAIL b2b_first_s: got %h want 26", s); end
    @(posedge clk); #1;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
    run_op(NN + 256'd3, NN + 256'd7, 256'd1, 256'd1, 1'b0, lat);
    nvec++; if (lat !== LAT_NORMAL || r !== 256'd3 || s !== 256'd10) begin
      nerr++; $display("FAIL b2b_second: lat=%0d r=%h s=%h want %0d/3/a", lat, r, s, LAT_NORMAL);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_trivial();
    test_reduction();
    test_wrap();
    test_small_product();
    test_degenerate_r();
    test_degenerate_s();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ecdsa_sig_finalize.md
# ecdsa_sig_finalize

Downstream of the scalar multiplier in the ECDSA signing datapath. Takes the x-coordinate of R = k·G and produces the signature pair: r = Rx mod n and s = k⁻¹·(z + r·d) mod n. The inputs are the message hash z, private key d and precomputed nonce inverse k_inv. The block uses one bit-serial modular multiplier, time-shared for the two products, and flags degenerate signatures (r = 0 or s = 0) so the controller can retry with a new nonce.

## Interface
- W, 256, operand width in bits.
- N, secp256k1 order 0xFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141, curve order n. Must satisfy 2^(W-1) < N < 2^W.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block idle and able to accept; high exactly in IDLE.
- rx  in  W  x-coordinate of R; must be < 2N.
- z  in  W  message hash; any W-bit value.
- d  in  W  private key, in [1, N-1].
- k_inv  in  W  nonce inverse mod N, in [1, N-1].
- r  out  W  signature r.
- s  out  W  signature s.
- err  out  1  r = 0 or s = 0; signature unusable.
- out_valid  out  1  r, s, err valid.
- out_ready  in  1  consumer accepts result.

## Operation
- States: IDLE, LOAD, MUL1, ADD, MUL2, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, capture rx, z, d, k_inv, then go to LOAD.
- LOAD:
  - r_reg = rx ≥ N ? rx − N : rx.
  - z_reg = z ≥ N ? z − N : z.
  - If r_reg = 0: go to DONE with err = 1 and s = 0.
  - Otherwise load the multiplier with (a = r_reg, b = d) and go to MUL1.
- MUL1: 256 iterations, MSB-first interleaved multiply, one bit per cycle.
  - acc ← 2·acc mod N.
  - Then, if b[i] = 1, acc ← acc + a mod N.
  - Each step is bounded by conditional subtractions on a W+1-bit intermediate. acc starts at 0.
  - After the last iteration, t = acc; go to ADD.
- ADD:
  - u = z_reg + t, minus N if ≥ N, using a W+1-bit sum.
  - Load the multiplier with (a = k_inv, b = u) and go to MUL2.
- MUL2:
  - Same 256 iterations as MUL1. On the last iteration, s = acc.
  - err = (acc == 0). Go to DONE.
- DONE:
  - out_valid = 1; r, s, err held stable.
  - On out_ready, go to IDLE. r, s, err keep their values until the next capture.
- Inputs are ignored outside IDLE. in_valid in non-IDLE states has no effect.
- Inputs d, k_inv ≥ N: result unspecified, no hang. The FSM still completes in the stated cycle count.

## Timing
- Reset values:
  - state = IDLE, in_ready = 1 (first cycle after reset).
  - out_valid = 0, err = 0, r = 0, s = 0.
  - Iteration counter = 0, acc = 0.
- Reset mid-operation: the current computation is aborted and outputs return to reset values on the next edge. There is no partial output.
- Accept edge = E0. LOAD executes at E1, MUL1 at E2..E257, ADD at E258, MUL2 at E259..E514.
  - Normal path: out_valid rises after E514, i.e. 514 cycles after accept.
  - r = 0 path: out_valid rises after E1.
- Handshake completes on the edge where out_valid & out_ready. in_ready is high in the following cycle.
  - Throughput: one signature per 516 cycles with out_ready tied high.
- out_ready may be high before out_valid; it is only sampled in DONE.
- Iteration counter: 8 bits, counting down 255→0 to index b. Wrap-around is not used; the 0 state terminates the phase.

## Structure
- Shared package ecdsa_pkg:
  - Curve constant ECDSA_N.
  - W.
  - The sig_state_t enum (IDLE..DONE), reused by the top-level sign controller.
- Sub-module mod_mul_serial (W, N).
  - Ports: start, a, b, busy, done, p.
  - Fixed 256-cycle latency; done is a 1-cycle pulse.
  - Instantiated once and shared by MUL1 and MUL2.
- The modular-reduce/add helpers are combinational logic inside the top module.

## Test plan
- Trivial path: rx=5, d=1, k_inv=1, z=0 → r=5, s=5, err=0. out_valid exactly 514 cycles after accept.
- Reduction: rx=N+3, z=N+7, d=1, k_inv=1 → r=3, s=10. Checks both conditional subtracts in LOAD.
- Wrap in multiply: rx=2, d=N−1, k_inv=1, z=0 → r=2, s=N−2. Checks the MUL1 mod reduction.
- Degenerate cases:
  - rx=N → r=0, err=1, s=0, out_valid after 1 cycle.
  - rx=1, d=1, z=N−1, k_inv=7 → u=0, s=0, err=1.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles in DONE → r/s/err stable, in_ready=0. Release → IDLE next cycle, then a second operation is accepted.
  - rst=1 at cycle 100 of MUL1 → all outputs zero, in_ready=1 after one edge. The next operation completes correctly.
